// File: rtl/instr_pkg.sv
// instr_pkg: shared opcode encodings, instruction word layout and opcode classification helpers
package instr_pkg;
  localparam int DEF_OPCODE_WIDTH = 3;
  localparam int DEF_OPERAND_WIDTH = 8;
  typedef enum logic [DEF_OPCODE_WIDTH-1:0] {
    OP_ADD  = 3'd0,
    OP_MAC  = 3'd1,
    OP_WAIT = 3'd2,
    OP_SETB = 3'd3,
    OP_SETD = 3'd4,
    OP_SETE = 3'd5
  } opcode_e;
  typedef struct packed {
    opcode_e opcode;
    logic [DEF_OPERAND_WIDTH-1:0] operand;
  } instr_word_t;
  function automatic logic is_legal_opcode(input logic [DEF_OPCODE_WIDTH-1:0] op);
    return op inside {OP_ADD, OP_MAC, OP_WAIT, OP_SETB, OP_SETD, OP_SETE};
  endfunction
  function automatic logic is_wait(input logic [DEF_OPCODE_WIDTH-1:0] op);
    return op == OP_WAIT;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: FIFO with registered first-word-fall-through head (push/din in, pop, dout/full/empty/level out)
module sync_fifo #(
  parameter int W = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               din,
  input  logic                       pop,
  output logic [W-1:0]               dout,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [LW-1:0] level_nxt;
  always_comb begin
    rd_nxt = pop ? rd_ptr + AW'(1) : rd_ptr;
    level_nxt = level + LW'(push) - LW'(pop);
  end
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
      full <= 1'b0;
      empty <= 1'b1;
      dout <= '0;
    end else begin
      wr_ptr <= push ? wr_ptr + AW'(1) : wr_ptr;
      rd_ptr <= rd_nxt;
      level <= level_nxt;
      full <= level_nxt == LW'(DEPTH);
      empty <= level_nxt == '0;
      dout <= level_nxt == '0 ? '0 : level == LW'(pop) ? din : mem[rd_nxt];
    end
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: buffers opcode/operand requests and issues registered instruction words with WAIT expansion (req_* in, instr_* out, err_illegal, fifo_level)
module instr_encoder import instr_pkg::*; #(
  parameter int OPCODE_WIDTH = DEF_OPCODE_WIDTH,
  parameter int OPERAND_WIDTH = DEF_OPERAND_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [OPCODE_WIDTH-1:0]             req_opcode,
  input  logic [OPERAND_WIDTH-1:0]            req_operand,
  output logic                                instr_valid,
  input  logic                                instr_ready,
  output logic [OPCODE_WIDTH+OPERAND_WIDTH-1:0] instr_word,
  output logic                                err_illegal,
  output logic [$clog2(DEPTH+1)-1:0]          fifo_level
);
  localparam int W = OPCODE_WIDTH + 2*OPERAND_WIDTH;
  logic [W-1:0] din, dout;
  logic [OPERAND_WIDTH-1:0] cnt, head_n;
  logic full, empty, accept, legal, push, fire, head_wait, last, pop;
  always_comb begin
    accept = req_valid && req_ready;
    legal = is_legal_opcode(req_opcode);
    push = accept && legal;
    din = {req_opcode, is_wait(req_opcode) ? {OPERAND_WIDTH{1'b0}} : req_operand, req_operand};
    fire = instr_valid && instr_ready;
    head_wait = is_wait(dout[W-1 -: OPCODE_WIDTH]);
    head_n = dout[OPERAND_WIDTH-1:0];
    last = cnt == '0 ? head_n <= OPERAND_WIDTH'(1) : cnt == OPERAND_WIDTH'(1);
    pop = fire && (!head_wait || last);
  end
  sync_fifo #(.W(W), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .push(push), .din(din), .pop(pop),
    .dout(dout), .full(full), .empty(empty), .level(fifo_level)
  );
  assign req_ready = !full;
  assign instr_valid = !empty;
  assign instr_word = dout[W-1 -: OPCODE_WIDTH+OPERAND_WIDTH];
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      err_illegal <= 1'b0;
    end else begin
      if (fire && head_wait) cnt <= last ? '0 : cnt == '0 ? head_n - OPERAND_WIDTH'(1) : cnt - OPERAND_WIDTH'(1);
      if (accept && !legal) err_illegal <= 1'b1;
    end
  end
endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed and randomized checks of instr_encoder against a word-queue reference model
module tb_instr_encoder;
  import instr_pkg::*;
  localparam int OW = 3, DW = 8, DEPTH = 4, LW = $clog2(DEPTH+1);
  logic clk = 1'b0;
  logic rst, req_valid, req_ready, instr_valid, instr_ready, err_illegal;
  logic [OW-1:0] req_opcode;
  logic [DW-1:0] req_operand;
  logic [OW+DW-1:0] instr_word;
  logic [LW-1:0] fifo_level;
  int errors = 0, checks = 0;
  logic [OW+DW-1:0] words[$];
  int ent[$];
  bit err_m, armed, just_reset;
  always #5 clk = ~clk;
  instr_encoder #(.OPCODE_WIDTH(OW), .OPERAND_WIDTH(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_opcode(req_opcode), .req_operand(req_operand), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .instr_word(instr_word), .err_illegal(err_illegal),
    .fifo_level(fifo_level)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input bit r, input bit rv, input logic [OW-1:0] op, input logic [DW-1:0] opr, input bit ir);
    bit acc, fire, legal;
    int n;
    @(negedge clk);
    if (armed) begin
      check("instr_valid", 32'(instr_valid), 32'(words.size() > 0));
      if (words.size() > 0) check("instr_word", 32'(instr_word), 32'(words[0]));
      if (just_reset) check("reset_word", 32'(instr_word), 32'd0);
      check("req_ready", 32'(req_ready), 32'(ent.size() < DEPTH));
      check("fifo_level", 32'(fifo_level), 32'(ent.size()));
      check("err_illegal", 32'(err_illegal), 32'(err_m));
    end
    just_reset = 1'b0;
    rst = r; req_valid = rv; req_opcode = op; req_operand = opr; instr_ready = ir;
    acc = rv && ent.size() < DEPTH;
    fire = words.size() > 0 && ir;
    @(posedge clk);
    if (r) begin
      words.delete(); ent.delete(); err_m = 1'b0; armed = 1'b1; just_reset = 1'b1;
    end else begin
      if (fire) begin
        void'(words.pop_front());
        ent[0] = ent[0] - 1;
        if (ent[0] == 0) void'(ent.pop_front());
      end
      if (acc) begin
        legal = op inside {OP_ADD, OP_MAC, OP_WAIT, OP_SETB, OP_SETD, OP_SETE};
        if (!legal) err_m = 1'b1;
        else begin
          n = (op == OP_WAIT && opr > 0) ? int'(opr) : 1;
          ent.push_back(n);
          repeat (n) words.push_back({op, op == OP_WAIT ? 8'h00 : opr});
        end
      end
    end
  endtask
  task automatic idle(input int k, input bit ir);
    repeat (k) cycle(0, 0, 3'd0, 8'd0, ir);
  endtask
  initial begin
    rst = 1'b1; req_valid = 1'b0; req_opcode = '0; req_operand = '0; instr_ready = 1'b0;
    cycle(1, 1, OP_ADD, 8'h33, 1);
    cycle(1, 1, OP_MAC, 8'h44, 1);
    idle(1, 1);
    cycle(0, 1, OP_ADD, 8'h12, 1);
    idle(3, 1);
    cycle(0, 1, OP_WAIT, 8'd3, 1);
    cycle(0, 1, OP_SETB, 8'h05, 1);
    idle(6, 1);
    cycle(0, 1, OP_WAIT, 8'd0, 1);
    cycle(0, 1, OP_SETB, 8'h05, 1);
    idle(4, 1);
    for (int i = 1; i <= 4; i++) cycle(0, 1, OP_MAC, 8'(i), 0);
    repeat (3) cycle(0, 1, OP_MAC, 8'd5, 0);
    repeat (2) cycle(0, 1, OP_MAC, 8'd5, 1);
    idle(7, 1);
    cycle(0, 1, 3'd7, 8'hAA, 1);
    for (int i = 0; i < 10; i++) cycle(0, 1, OP_SETD, 8'(i), 1);
    idle(3, 1);
    cycle(0, 1, OP_WAIT, 8'd5, 1);
    idle(2, 1);
    cycle(1, 0, 3'd0, 8'd0, 1);
    cycle(0, 1, OP_SETE, 8'h01, 1);
    idle(2, 1);
    for (int i = 0; i < 1500; i++) begin
      logic [OW-1:0] op;
      logic [DW-1:0] opr;
      op = OW'($urandom_range(0, 7));
      opr = (op == OP_WAIT) ? (($urandom_range(0, 9) == 0) ? DW'($urandom_range(0, 40)) : DW'($urandom_range(0, 3))) : DW'($urandom);
      cycle($urandom_range(0, 199) == 0, $urandom_range(0, 1) == 1, op, opr, $urandom_range(0, 3) != 0);
    end
    idle(80, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
